// File: rtl/fod_ctrl_v2.sv
// -----------------------------------------------------------------------------
// fod_ctrl_v2
// Second-generation FOD digital controller. Runs on the divided (DTC) clock and
// turns an unsigned WI.WF frequency control word into per-cycle MMD division
// words and DTC delay words. A first-order delta-sigma accumulator supplies the
// fractional carry. An optional LFSR dither adds one LSB to the accumulator
// input to break up idle tones.
//
// Parameters
//   WI       FCW integer bits (MMD_DCW width)
//   WF       FCW fractional bits (phase accumulator width)
//   WD       DTC_DCW / KDTC width
//   MMD_MIN  smallest legal MMD division ratio
//   RT_THR   DTC code at or above which the retimer selects the late edge
//   FCW_RST  FCW value loaded by reset
//   ACC_CLR  1: clear accumulator on FCW reload, 0: keep phase continuity
//
// Ports
//   CLK       in   divided/DTC clock, all logic on rising edge
//   RST       in   synchronous active-high reset
//   EN        in   run enable
//   DSM_MODE  in   0 integer, 1 first-order, 2 first-order + dither, 3 as 1
//   FCW_FOD   in   requested FCW, unsigned WI.WF
//   FCW_LD    in   level-sampled request to load FCW_FOD
//   KDTC      in   DTC gain, full-scale code per VCO period
//   FCW_ACK   out  one-cycle pulse, new FCW now active
//   MMD_DCW   out  MMD division word
//   DTC_DCW   out  DTC delay word
//   RT_DCW    out  retimer edge select
//   SAT       out  sticky, MMD word saturated since last reset
// -----------------------------------------------------------------------------
module fod_ctrl_v2 #(
  parameter int unsigned       WI      = 6,
  parameter int unsigned       WF      = 16,
  parameter int unsigned       WD      = 10,
  parameter int unsigned       MMD_MIN = 4,
  parameter int unsigned       RT_THR  = 512,
  parameter logic [WI+WF-1:0]  FCW_RST = {WI'(4), WF'(0)},
  parameter logic              ACC_CLR = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       DSM_MODE,
  input  logic [WI+WF-1:0] FCW_FOD,
  input  logic             FCW_LD,
  input  logic [WD-1:0]    KDTC,
  output logic             FCW_ACK,
  output logic [WI-1:0]    MMD_DCW,
  output logic [WD-1:0]    DTC_DCW,
  output logic             RT_DCW,
  output logic             SAT
);

  localparam int unsigned   W          = WI + WF;
  localparam logic [WI:0]   MMD_MAX_X  = {1'b0, {WI{1'b1}}};
  localparam logic [WI:0]   MMD_MIN_X  = (WI+1)'(MMD_MIN);
  localparam logic [WD-1:0] RT_THR_C   = WD'(RT_THR);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LOAD
  } state_t;

  state_t        state, state_nxt;

  logic [W-1:0]  fcw_act, fcw_act_nxt;
  logic [W-1:0]  fcw_pend, fcw_pend_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic [WF-1:0] acc, acc_nxt;
  logic [15:0]   lfsr, lfsr_nxt;

  logic          ack_nxt;
  logic [WI-1:0] mmd_nxt;
  logic [WD-1:0] dtc_nxt;
  logic          rt_nxt;
  logic          sat_nxt;

  // ---------------------------------------------------------------------------
  // Running datapath, always evaluated against the currently active FCW so a
  // reload only takes effect one edge after the LOAD cycle.
  // ---------------------------------------------------------------------------
  logic          int_mode;
  logic          dith;
  logic [WF:0]   sum;
  logic [WF-1:0] acc_run;
  logic          carry;
  logic [WI:0]   m_raw;
  logic          m_hi;
  logic          m_lo;
  logic [WI-1:0] mmd_run;
  logic [WF+WD-1:0] prod;
  logic [WD-1:0] dtc_run;
  logic [15:0]   lfsr_step;

  assign int_mode = (DSM_MODE == 2'd0);
  assign dith     = (DSM_MODE == 2'd2) ? lfsr[0] : 1'b0;

  assign sum      = {1'b0, acc} + {1'b0, fcw_act[WF-1:0]} + {{WF{1'b0}}, dith};

  // Integer mode pins the accumulator at zero and suppresses the carry.
  assign acc_run  = int_mode ? '0 : sum[WF-1:0];
  assign carry    = int_mode ? 1'b0 : sum[WF];

  // One extra bit so the overflow of int(fcw)+carry is visible for clamping.
  assign m_raw    = {1'b0, fcw_act[W-1:WF]} + {{WI{1'b0}}, carry};
  assign m_hi     = (m_raw > MMD_MAX_X);
  assign m_lo     = (m_raw < MMD_MIN_X);
  assign mmd_run  = m_hi ? MMD_MAX_X[WI-1:0] :
                    m_lo ? MMD_MIN_X[WI-1:0] :
                           m_raw[WI-1:0];

  // acc < 2^WF and KDTC < 2^WD, so the top WD bits of the product never wrap.
  assign prod     = {{WD{1'b0}}, acc_run} * {{WF{1'b0}}, KDTC};
  assign dtc_run  = WD'(prod >> WF);

  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    fcw_act_nxt  = fcw_act;
    fcw_pend_nxt = fcw_pend;
    pend_vld_nxt = pend_vld;
    acc_nxt      = acc;
    lfsr_nxt     = lfsr;
    ack_nxt      = 1'b0;
    mmd_nxt      = MMD_DCW;
    dtc_nxt      = DTC_DCW;
    rt_nxt       = RT_DCW;
    sat_nxt      = SAT;

    unique case (state)
      S_IDLE: begin
        acc_nxt = '0;
        dtc_nxt = '0;
        rt_nxt  = 1'b0;
        mmd_nxt = fcw_act[W-1:WF];
        // A fresh request wins over one parked while leaving RUN.
        if (FCW_LD) begin
          fcw_act_nxt  = FCW_FOD;
          ack_nxt      = 1'b1;
          pend_vld_nxt = 1'b0;
        end else if (pend_vld) begin
          fcw_act_nxt  = fcw_pend;
          ack_nxt      = 1'b1;
          pend_vld_nxt = 1'b0;
        end
        if (EN) begin
          state_nxt = S_RUN;
        end
      end

      S_RUN, S_LOAD: begin
        acc_nxt = acc_run;
        mmd_nxt = mmd_run;
        dtc_nxt = dtc_run;
        rt_nxt  = (dtc_run >= RT_THR_C);
        if (m_hi || m_lo) begin
          sat_nxt = 1'b1;
        end
        if (DSM_MODE == 2'd2) begin
          lfsr_nxt = lfsr_step;
        end

        if (state == S_RUN) begin
          if (FCW_LD) begin
            fcw_pend_nxt = FCW_FOD;
            if (EN) begin
              state_nxt = S_LOAD;
            end else begin
              // Leaving RUN: the captured word is applied from IDLE instead.
              pend_vld_nxt = 1'b1;
              state_nxt    = S_IDLE;
            end
          end else if (!EN) begin
            state_nxt = S_IDLE;
          end
        end else begin
          // LOAD: FCW_LD is ignored here; the requester re-asserts after ACK.
          fcw_act_nxt = fcw_pend;
          ack_nxt     = 1'b1;
          if (ACC_CLR) begin
            acc_nxt = '0;
          end
          state_nxt = EN ? S_RUN : S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      fcw_act  <= FCW_RST;
      fcw_pend <= FCW_RST;
      pend_vld <= 1'b0;
      acc      <= '0;
      lfsr     <= LFSR_SEED;
      FCW_ACK  <= 1'b0;
      MMD_DCW  <= FCW_RST[W-1:WF];
      DTC_DCW  <= '0;
      RT_DCW   <= 1'b0;
      SAT      <= 1'b0;
    end else begin
      fcw_act  <= fcw_act_nxt;
      fcw_pend <= fcw_pend_nxt;
      pend_vld <= pend_vld_nxt;
      acc      <= acc_nxt;
      lfsr     <= lfsr_nxt;
      FCW_ACK  <= ack_nxt;
      MMD_DCW  <= mmd_nxt;
      DTC_DCW  <= dtc_nxt;
      RT_DCW   <= rt_nxt;
      SAT      <= sat_nxt;
    end
  end

endmodule
